muldiv_unit: RTL

// - Iterative RV32M multiply/divide execute unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
// - Consumes rs1/rs2 read data from the register file and returns a result plus rd address.
// - That result feeds the register file write port (rd_data/rd_addr/RegWrite) via the writeback mux.
// - The CPU stalls PC fetch while the unit is busy, so the single-cycle core can host multi-cycle ops.

---
 rtl/muldiv_unit.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle combinational one.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REG_DEPTH
`define REG_DEPTH 32
`endif

module muldiv_unit #(
  parameter int XLEN   = `DATA_WIDTH,
  parameter int REG_AW = $clog2(`REG_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              kill_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [XLEN-1:0]   result_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              wb_en_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
`ifndef MULDIV_FAST_MUL_EN
    , S_MUL = 2'd1
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [REG_AW-1:0]   rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]     acc_q, acc_d;      // product high half / remainder
  logic [XLEN-1:0]     lo_q, lo_d;        // product low half (multiplier) / quotient (dividend)
  logic [XLEN-1:0]     opb_q, opb_d;      // multiplicand / divisor magnitude
  logic                neg_q, neg_d;      // product or quotient must be negated
  logic                rneg_q, rneg_d;    // remainder must be negated
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [2*XLEN-1:0]   prod_full, prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix, fix;
  logic [XLEN:0]       div_shift;
  logic [XLEN-1:0]     div_diff;
  logic                div_ge;
`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN-1:0] fast_prod;
`else
  logic [XLEN:0]       mul_sum;
`endif

  always_comb begin
    // MUL is treated as signed x signed; its low half is the same either way.
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3_i)
      3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:                         a_signed = 1'b1;
      default:                        ;
    endcase
    a_neg = a_signed & rs1_data_i[XLEN-1];
    b_neg = b_signed & rs2_data_i[XLEN-1];
    a_mag = a_neg ? -rs1_data_i : rs1_data_i;
    b_mag = b_neg ? -rs2_data_i : rs2_data_i;

    prod_full = {acc_q, lo_q};
    prod_fix  = neg_q ? -prod_full : prod_full;
    quo_fix   = neg_q ? -lo_q : lo_q;
    rem_fix   = rneg_q ? -acc_q : acc_q;
    case (funct3_q)
      3'b000:                 fix = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix = quo_fix;
      default:                fix = rem_fix;
    endcase

    div_shift = {acc_q, lo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_diff  = div_shift[XLEN-1:0] - opb_q;
`ifdef MULDIV_FAST_MUL_EN
    fast_a    = {a_signed & rs1_data_i[XLEN-1], rs1_data_i};
    fast_b    = {b_signed & rs2_data_i[XLEN-1], rs2_data_i};
    fast_prod = fast_a * fast_b;
`else
    mul_sum   = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opb_q : '0)};
`endif
  end

  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    rd_addr_d = rd_addr_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    if (kill_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          funct3_d  = funct3_i;
          rd_addr_d = rd_addr_i;
          cnt_d     = CW'(XLEN - 1);
          if (!funct3_i[2]) begin
`ifdef MULDIV_FAST_MUL_EN
            acc_d   = fast_prod[2*XLEN-1:XLEN];
            lo_d    = fast_prod[XLEN-1:0];
            neg_d   = 1'b0;
            state_d = S_DONE;
`else
            acc_d   = '0;
            lo_d    = b_mag;
            opb_d   = a_mag;
            neg_d   = a_neg ^ b_neg;
            state_d = S_MUL;
`endif
          end else if (rs2_data_i == '0) begin
            // Divide by zero: quotient all ones, remainder is the dividend.
            lo_d    = '1;
            acc_d   = rs1_data_i;
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
            state_d = S_DONE;
          end else if (!funct3_i[0] && rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}
                       && rs2_data_i == '1) begin
            lo_d    = rs1_data_i;
            acc_d   = '0;
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            acc_d   = '0;
            lo_d    = a_mag;
            opb_d   = b_mag;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            state_d = S_DIV;
          end
        end
`ifndef MULDIV_FAST_MUL_EN
        S_MUL: begin
          acc_d = mul_sum[XLEN:1];
          lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = S_DONE;
        end
`endif
        S_DIV: begin
          acc_d = div_ge ? div_diff : div_shift[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], div_ge};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = S_DONE;
        end
        S_DONE: begin
          result_d = fix;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      funct3_q  <= '0;
      rd_addr_q <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      rd_addr_q <= rd_addr_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      opb_q     <= opb_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  // The fixed-up result is shown combinationally in DONE and held afterwards.
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign result_o  = done_o ? fix : result_q;
  assign rd_addr_o = rd_addr_q;
  assign wb_en_o   = done_o & (rd_addr_q != '0);

endmodule
